// File: rtl/imem_loader.sv
// Instruction-store loader: assembles a big-endian byte stream into 32-bit words,
//   writes them to a synchronous-read store and holds the CPU off until loaded.
// Latency: a word is written on the edge that accepts its 4th byte; fetch is 1 cycle.
// Backpressure: byte_ready is high only in LOAD; byte_valid low simply stalls the load.
//
// Ports:
//   clock, reset             - system clock, synchronous active-high reset
//   load_start, load_len     - request a load of load_len words (0 = run at once)
//   byte_in/_valid/_ready    - program byte stream, valid/ready handshake
//   load_done, load_err      - one-cycle status pulses
//   cpu_run                  - high while the CPU may execute (RUN state only)
//   pc, inst_out             - fetch-stage byte address in, registered instruction out
module imem_loader #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              load_done,
    output logic              load_err,
    output logic              cpu_run,
    input  logic [31:0]       pc,
    output logic [DATA_W-1:0] inst_out
);

    localparam int DEPTH = 1 << ADDR_W;
    // Largest legal length: exactly a full store.
    localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [ADDR_W:0]     word_cnt_q, word_cnt_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic                load_done_q, load_done_d;
    logic                load_err_q, load_err_d;
    logic [DATA_W-1:0]   inst_q, inst_d;

    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [ADDR_W:0]     word_cnt_inc;
    logic                fetch_ok;

    // Byte offset within the word never affects the fetch.
    logic                unused_pc_lo;
    assign unused_pc_lo = ^pc[1:0];

    assign word_cnt_inc = word_cnt_q + 1'b1;
    assign wr_addr      = word_cnt_q[ADDR_W-1:0];
    assign fetch_ok     = (state_q == S_RUN) && (pc[31:ADDR_W+2] == '0);

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        word_cnt_d  = word_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        word_d      = word_q;
        load_done_d = 1'b0;
        load_err_d  = 1'b0;
        wr_en       = 1'b0;
        inst_d      = fetch_ok ? mem_q[pc[ADDR_W+1:2]] : '0;

        case (state_q)
            S_IDLE, S_RUN: begin
                if (load_start) begin
                    if (load_len == '0) begin
                        state_d     = S_RUN;
                        load_done_d = 1'b1;
                    end else if (load_len > LEN_MAX) begin
                        load_err_d  = 1'b1;
                    end else begin
                        state_d    = S_LOAD;
                        len_d      = load_len;
                        word_cnt_d = '0;
                        byte_cnt_d = '0;
                        word_d     = '0;
                    end
                end
            end
            S_LOAD: begin
                // load_start is deliberately ignored while a load is in flight.
                if (byte_valid) begin
                    // Shifting in from the bottom leaves the first byte in [31:24].
                    word_d = {word_q[DATA_W-9:0], byte_in};
                    if (byte_cnt_q == 2'd3) begin
                        wr_en      = 1'b1;
                        word_cnt_d = word_cnt_inc;
                        byte_cnt_d = '0;
                        if (word_cnt_inc == len_q) begin
                            state_d     = S_RUN;
                            load_done_d = 1'b1;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            word_cnt_q  <= '0;
            byte_cnt_q  <= '0;
            word_q      <= '0;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
            inst_q      <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            word_cnt_q  <= word_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            word_q      <= word_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
            inst_q      <= inst_d;
        end
    end

    // Store is not reset: words already loaded survive a reset.
    always_ff @(posedge clock) begin
        if (wr_en && !reset) begin
            mem_q[wr_addr] <= word_d;
        end
    end

    assign byte_ready = (state_q == S_LOAD);
    assign cpu_run    = (state_q == S_RUN);
    assign load_done  = load_done_q;
    assign load_err   = load_err_q;
    assign inst_out   = inst_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed program loads with a transaction-level model
//   (byte queue -> word array) compared against the DUT every cycle, plus literal checks.
module tb_imem_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        load_start = 1'b0;
    logic [6:0]  load_len = '0;
    logic [7:0]  byte_in = '0;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic        load_done;
    logic        load_err;
    logic        cpu_run;
    logic [31:0] pc = '0;
    logic [31:0] inst_out;

    always #5 clock = ~clock;

    imem_loader dut (
        .clock      (clock),
        .reset      (reset),
        .load_start (load_start),
        .load_len   (load_len),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .load_done  (load_done),
        .load_err   (load_err),
        .cpu_run    (cpu_run),
        .pc         (pc),
        .inst_out   (inst_out)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 = idle, 1 = loading, 2 = running
    int          mode = 0;
    logic [31:0] mmem [64];
    logic [7:0]  bq [$];
    int          target = 0;
    int          written = 0;
    bit          exp_done = 1'b0;
    bit          exp_err = 1'b0;
    logic [31:0] exp_inst = '0;
    bit          model_ok = 1'b0;

    always @(posedge clock) begin
        logic [31:0] nxt_inst;
        nxt_inst = (mode == 2 && pc < 32'h100) ? mmem[int'(pc / 4)] : 32'h0;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        if (reset) begin
            mode     = 0;
            bq.delete();
            exp_inst = '0;
            model_ok = 1'b1;
        end else begin
            exp_inst = nxt_inst;
            if (mode != 1 && load_start) begin
                if (load_len == 0) begin
                    mode     = 2;
                    exp_done = 1'b1;
                end else if (int'(load_len) > 64) begin
                    exp_err = 1'b1;
                end else begin
                    mode    = 1;
                    target  = int'(load_len);
                    written = 0;
                    bq.delete();
                end
            end else if (mode == 1 && byte_valid) begin
                bq.push_back(byte_in);
                if (bq.size() == 4) begin
                    mmem[written] = {bq[0], bq[1], bq[2], bq[3]};
                    written++;
                    bq.delete();
                    if (written == target) begin
                        mode     = 2;
                        exp_done = 1'b1;
                    end
                end
            end
        end
    end

    always @(negedge clock) begin
        if (model_ok) begin
            chk("m_byte_ready", 32'(byte_ready), 32'(mode == 1));
            chk("m_cpu_run",    32'(cpu_run),    32'(mode == 2));
            chk("m_load_done",  32'(load_done),  32'(exp_done));
            chk("m_load_err",   32'(load_err),   32'(exp_err));
            chk("m_inst_out",   inst_out,        exp_inst);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    task automatic start(input int len);
        load_start = 1'b1;
        load_len   = 7'(len);
        cyc();
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_in    = b;
        byte_valid = 1'b1;
        cyc();
        byte_valid = 1'b0;
    endtask

    logic [7:0] prog1 [8] = '{8'h40, 8'h22, 8'h00, 8'h0F, 8'h40, 8'h43, 8'h00, 8'h0F};
    logic [7:0] prog2 [4] = '{8'h28, 8'hA2, 8'h00, 8'h08};

    initial begin
        // Reset
        reset = 1'b1;
        cyc();
        cyc();
        chk("rst_byte_ready", 32'(byte_ready), 32'd0);
        chk("rst_cpu_run",    32'(cpu_run),    32'd0);
        chk("rst_inst_out",   inst_out,        32'd0);
        reset = 1'b0;
        cyc();

        // Out-of-range length from IDLE
        start(65);
        chk("len65_err",        32'(load_err),   32'd1);
        chk("len65_byte_ready", 32'(byte_ready), 32'd0);
        chk("len65_cpu_run",    32'(cpu_run),    32'd0);
        cyc();
        chk("len65_err_pulse",  32'(load_err),   32'd0);

        // Load 1: two words, valid held high
        start(2);
        chk("load1_ready", 32'(byte_ready), 32'd1);
        for (int i = 0; i < 8; i++) send_byte(prog1[i]);
        chk("load1_done",       32'(load_done),  32'd1);
        chk("load1_cpu_run",    32'(cpu_run),    32'd1);
        chk("load1_byte_ready", 32'(byte_ready), 32'd0);
        pc = 32'd0;
        cyc();
        chk("load1_fetch0", inst_out, 32'h4022000F);
        chk("load1_done_pulse", 32'(load_done), 32'd0);
        pc = 32'd4;
        cyc();
        chk("load1_fetch1", inst_out, 32'h4043000F);

        // Stall: 3 idle cycles between bytes 2 and 3
        start(2);
        chk("stall_cpu_run", 32'(cpu_run), 32'd0);
        for (int i = 0; i < 8; i++) begin
            send_byte(prog1[i]);
            if (i == 1) begin
                cyc();
                cyc();
                cyc();
                chk("stall_no_done", 32'(load_done), 32'd0);
            end
        end
        chk("stall_done", 32'(load_done), 32'd1);
        pc = 32'd0;
        cyc();
        chk("stall_fetch0", inst_out, 32'h4022000F);
        pc = 32'd4;
        cyc();
        chk("stall_fetch1", inst_out, 32'h4043000F);

        // Zero length: immediate done, stays running
        start(0);
        chk("len0_done",    32'(load_done), 32'd1);
        chk("len0_cpu_run", 32'(cpu_run),   32'd1);

        // Reload one word from RUN
        pc = 32'd0;
        start(1);
        chk("reload_cpu_run", 32'(cpu_run), 32'd0);
        send_byte(prog2[0]);
        chk("reload_nop", inst_out, 32'd0);
        for (int i = 1; i < 4; i++) send_byte(prog2[i]);
        chk("reload_done", 32'(load_done), 32'd1);
        cyc();
        chk("reload_fetch0", inst_out, 32'h28A20008);
        pc = 32'd4;
        cyc();
        chk("reload_fetch1", inst_out, 32'h4043000F);

        // Reset in the middle of a word, then a clean one-word load
        start(1);
        send_byte(8'hAA);
        send_byte(8'hBB);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("midrst_byte_ready", 32'(byte_ready), 32'd0);
        chk("midrst_cpu_run",    32'(cpu_run),    32'd0);
        start(1);
        send_byte(8'h11);
        send_byte(8'h22);
        load_start = 1'b1;          // ignored while loading
        load_len   = 7'd5;
        send_byte(8'h33);
        load_start = 1'b0;
        send_byte(8'h44);
        chk("midrst_done", 32'(load_done), 32'd1);
        chk("midrst_err",  32'(load_err),  32'd0);
        pc = 32'd0;
        cyc();
        chk("midrst_fetch0", inst_out, 32'h11223344);
        pc = 32'd4;
        cyc();
        chk("midrst_fetch1", inst_out, 32'h4043000F);
        pc = 32'h100;
        cyc();
        chk("pc_out_of_range", inst_out, 32'd0);
        pc = 32'd3;
        cyc();
        chk("pc_low_bits_ignored", inst_out, 32'h11223344);
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_chk, n_fail);
        $fatal(1);
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write side of the instruction memory that the dlxpipeline fetch stage reads through its pc / inst_in path.
- Accepts a program as a byte stream over a valid/ready handshake and assembles big-endian 32-bit words into a synchronous-read instruction store.
- Holds the CPU idle (cpu_run low) while loading and releases it when the programmed word count has been written.
- Replaces hand-poked inst_i stimulus: benches and boot logic load real programs, and the pipeline then fetches them.

Parameters:
- ADDR_W, 6, log2 of store depth in words (64 words default).
- DATA_W, 32, instruction word width; fixed at 32, and byte assembly assumes 4 bytes per word.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- load_start  input  1  one-cycle request to begin a program load.
- load_len  input  ADDR_W+1  number of words to load; sampled on the cycle load_start is accepted.
- byte_in  input  8  program byte.
- byte_valid  input  1  byte_in is valid this cycle.
- byte_ready  output  1  loader accepts a byte this cycle.
- load_done  output  1  one-cycle pulse when the last word is written.
- load_err  output  1  one-cycle pulse when load_len is out of range.
- cpu_run  output  1  high when the CPU may execute; low holds it off.
- pc  input  32  byte address from the fetch stage.
- inst_out  output  32  fetched instruction, registered.

Behaviour:
- States: IDLE, LOAD, RUN.
- Reset: state goes to IDLE. Also clears word_cnt, byte_cnt and the word shift register. Outputs at reset: byte_ready=0, load_done=0, load_err=0, cpu_run=0, inst_out=0. Store contents are not cleared.
- IDLE, load_start=1:
  - load_len=0 -> go to RUN and pulse load_done; no writes.
  - load_len > 2^ADDR_W -> pulse load_err and stay in IDLE.
  - Otherwise latch len, clear counters, go to LOAD.
- RUN, load_start=1: same rules as IDLE. On a valid len, cpu_run drops in the same edge as the LOAD transition.
- load_start while in LOAD: ignored.
- LOAD:
  - byte_ready=1 in LOAD only.
  - A byte transfers on any edge with byte_valid & byte_ready.
  - Byte order: byte_cnt 0 -> bits [31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0].
  - On the 4th byte, write the assembled word (including the 4th byte) to mem[word_cnt] on that edge, increment word_cnt, and reset byte_cnt to 0.
  - If the incremented word_cnt equals len: next state RUN, load_done=1 for exactly one cycle, cpu_run=1 from that cycle on. byte_ready is 0 in that same cycle.
  - byte_valid low stalls without losing partial-word state; there is no timeout.
- cpu_run=1 only in RUN.
- Fetch:
  - inst_out updates every edge: inst_out <= mem[pc[ADDR_W+1:2]] when state==RUN and pc[31:ADDR_W+2]==0; otherwise 0 (NOP).
  - Latency is one cycle; pc[1:0] is ignored.
  - Fetches are blocked during LOAD, so there are no read/write collisions.
- Reset mid-LOAD: the partial word is discarded, the state goes to IDLE, and any words already written remain in the store.

Test Plan:
- Reset -> byte_ready=0, cpu_run=0, inst_out=0.
- Load 1: load_start with load_len=2, then stream bytes 40 22 00 0F 40 43 00 0F with valid held high -> mem[0]=0x4022000F, mem[1]=0x4043000F. load_done pulses on the 8th-byte edge and cpu_run=1. With pc=0 then pc=4, inst_out = 0x4022000F then 0x4043000F, each one cycle after pc is applied.
- Stall: same 8 bytes with byte_valid deasserted for 3 cycles between bytes 2 and 3 -> identical memory contents. load_done arrives 3 cycles later than in Load 1.
- Length errors:
  - load_len=65 (ADDR_W=6) -> load_err pulse, state stays IDLE, byte_ready=0.
  - load_len=0 -> load_done pulse immediately, cpu_run=1.
- Reload: in RUN, issue load_start with load_len=1 -> cpu_run=0 and inst_out=0 next cycle. Load bytes 28 A2 00 08 -> mem[0]=0x28A20008, mem[1] unchanged; cpu_run returns to 1.
- Mid-load reset and range checks:
  - Reset after 2 bytes of a word -> IDLE; a new load of 1 word writes exactly the 4 new bytes.
  - pc=0x100 in RUN -> inst_out=0.
  - load_start during LOAD -> ignored.
